// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner and fetch FIFO feeding decode over valid/ready
//
// Ports:
//   Clk, Reset                    clock, synchronous active-high reset
//   ImemAddress / ImemInstruction word index out, combinational instruction word back
//   IfValid, IfInstr, IfPC,       head of the fetch FIFO; instr/pc read 0 while empty
//   IfPCPlus4
//   IdReady                       decode accepts the head this cycle
//   BranchTaken, BranchTarget     redirect pulse and byte target (low two bits ignored)
//   PerfFetchCount,               saturating push / stall counters, present only when
//   PerfStallCount                FETCH_PERF_EN is defined
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DEPTH      = 2,
    parameter int          IMEM_WORDS = 128
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemInstruction,
    output logic        IfValid,
    output logic [31:0] IfInstr,
    output logic [31:0] IfPC,
    output logic [31:0] IfPCPlus4,
    input  logic        IdReady,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] PerfFetchCount,
    output logic [31:0] PerfStallCount
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   fifo_instr_d [DEPTH];
    logic [31:0]   fifo_pc_q    [DEPTH];
    logic [31:0]   fifo_pc_d    [DEPTH];

    logic pop;
    logic push;

    assign IfValid   = (count_q != '0);
    assign IfInstr   = IfValid ? fifo_instr_q[rd_ptr_q] : 32'h0;
    assign IfPC      = IfValid ? fifo_pc_q[rd_ptr_q]    : 32'h0;
    assign IfPCPlus4 = IfPC + 32'd4;

    // Only the word index wraps; pc_q keeps counting through the full 32-bit space.
    assign ImemAddress = {2'b00, pc_q[31:2]} & 32'(IMEM_WORDS - 1);

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign pop  = IfValid & IdReady;
    assign push = !BranchTaken & ((count_q < CW'(DEPTH)) | pop);

    always_comb begin
        pc_d         = pc_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;
        if (BranchTaken) begin
            // Flush wins over the pop; a head popped this cycle was already delivered.
            pc_d     = BranchTarget & 32'hFFFF_FFFC;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                fifo_instr_d[wr_ptr_q] = ImemInstruction;
                fifo_pc_d[wr_ptr_q]    = pc_q;
                wr_ptr_d               = wr_ptr_q + PW'(1);
                pc_d                   = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr_q[i] <= 32'h0;
                fifo_pc_q[i]    <= 32'h0;
            end
        end else begin
            pc_q         <= pc_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            fifo_instr_q <= fifo_instr_d;
            fifo_pc_q    <= fifo_pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    assign PerfFetchCount = perf_fetch_q;
    assign PerfStallCount = perf_stall_q;

    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        if (push && (perf_fetch_q != 32'hFFFF_FFFF)) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end
        if (IfValid && !IdReady && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            perf_fetch_q <= 32'h0;
            perf_stall_q <= 32'h0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        tie_zero = 1'b0;
    logic [31:0] tie_target = 32'h0;

    logic [31:0] imem_address, imem_instruction;
    logic        if_valid;
    logic [31:0] if_instr, if_pc, if_pc_plus4;

    logic [31:0] w_imem_address, w_imem_instruction;
    logic        w_if_valid;
    logic [31:0] w_if_instr, w_if_pc, w_if_pc_plus4;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch, perf_stall, w_perf_fetch, w_perf_stall;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Instruction memory model: word i holds 32'hA000_0000 + i.
    assign imem_instruction   = 32'hA000_0000 + imem_address;
    assign w_imem_instruction = 32'hA000_0000 + w_imem_address;

    instruction_fetch_unit u_dut (
        .Clk(clk), .Reset(reset),
        .ImemAddress(imem_address), .ImemInstruction(imem_instruction),
        .IfValid(if_valid), .IfInstr(if_instr), .IfPC(if_pc), .IfPCPlus4(if_pc_plus4),
        .IdReady(id_ready), .BranchTaken(branch_taken), .BranchTarget(branch_target)
`ifdef FETCH_PERF_EN
        , .PerfFetchCount(perf_fetch), .PerfStallCount(perf_stall)
`endif
    );

    instruction_fetch_unit #(.RESET_PC(32'h0000_01FC), .DEPTH(2), .IMEM_WORDS(128)) u_wrap (
        .Clk(clk), .Reset(reset),
        .ImemAddress(w_imem_address), .ImemInstruction(w_imem_instruction),
        .IfValid(w_if_valid), .IfInstr(w_if_instr), .IfPC(w_if_pc), .IfPCPlus4(w_if_pc_plus4),
        .IdReady(id_ready), .BranchTaken(tie_zero), .BranchTarget(tie_target)
`ifdef FETCH_PERF_EN
        , .PerfFetchCount(w_perf_fetch), .PerfStallCount(w_perf_stall)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; id_ready = 1'b1; branch_taken = 1'b0; branch_target = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
                errors++;
                $display("FAIL reset_hold[%0d] valid=%b pc=%h instr=%h want 0/0/0", i, if_valid, if_pc, if_instr);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_instr !== 32'hA000_0000 + 32'(i)
                || if_pc_plus4 !== 32'(4 * i + 4)) begin
                errors++;
                $display("FAIL stream[%0d] valid=%b pc=%h instr=%h pc4=%h want 1/%h/%h/%h", i, if_valid,
                         if_pc, if_instr, if_pc_plus4, 32'(4 * i), 32'hA000_0000 + 32'(i), 32'(4 * i + 4));
            end
        end
    endtask

    task automatic test_stall();
        reset = 1'b1;
        step();
        reset = 1'b0; id_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || imem_address !== 32'd2) begin
            errors++;
            $display("FAIL stall_hold valid=%b pc=%h addr=%0d want 1/0/2", if_valid, if_pc, imem_address);
        end
        id_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            step();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_instr !== 32'hA000_0000 + 32'(i)) begin
                errors++;
                $display("FAIL stall_drain[%0d] valid=%b pc=%h instr=%h want 1/%h", i, if_valid, if_pc,
                         if_instr, 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect();
        // After the drain the FIFO holds PCs 8 and 12 (full); stall it and redirect.
        id_ready = 1'b0;
        branch_taken = 1'b1; branch_target = 32'h43;
        step();
        branch_taken = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || imem_address !== 32'd16) begin
            errors++;
            $display("FAIL redirect_bubble valid=%b pc=%h instr=%h addr=%0d want 0/0/0/16", if_valid,
                     if_pc, if_instr, imem_address);
        end
        step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_pc_plus4 !== 32'h44 || if_instr !== 32'hA000_0010) begin
            errors++;
            $display("FAIL redirect_target valid=%b pc=%h pc4=%h instr=%h want 1/40/44/a0000010", if_valid,
                     if_pc, if_pc_plus4, if_instr);
        end
        // Redirect while decode pops the head: flush still empties the FIFO next cycle.
        id_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0100;
        step();
        branch_taken = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || imem_address !== 32'd64) begin
            errors++;
            $display("FAIL redirect_pop valid=%b addr=%0d want 0/64", if_valid, imem_address);
        end
        step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h100) begin
            errors++;
            $display("FAIL redirect_pop_target valid=%b pc=%h want 1/100", if_valid, if_pc);
        end
    endtask

    task automatic test_wrap();
        reset = 1'b1; id_ready = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (w_imem_address !== 32'd127 || w_if_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_addr0 addr=%0d valid=%b want 127/0", w_imem_address, w_if_valid);
        end
        step();
        checks++;
        if (w_if_pc !== 32'h1FC || w_imem_address !== 32'd0 || w_if_instr !== 32'hA000_007F) begin
            errors++;
            $display("FAIL wrap_first pc=%h addr=%0d instr=%h want 1fc/0/a000007f", w_if_pc, w_imem_address,
                     w_if_instr);
        end
        step();
        checks++;
        if (w_if_pc !== 32'h200 || w_if_instr !== 32'hA000_0000 || w_if_pc_plus4 !== 32'h204) begin
            errors++;
            $display("FAIL wrap_second pc=%h instr=%h pc4=%h want 200/a0000000/204", w_if_pc, w_if_instr,
                     w_if_pc_plus4);
        end
    endtask

    task automatic test_reset_mid_stall();
        reset = 1'b1;
        step();
        reset = 1'b0; id_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0; id_ready = 1'b1;
        checks++;
        if (if_valid !== 1'b0 || imem_address !== 32'd0) begin
            errors++;
            $display("FAIL rst_stall_flush valid=%b addr=%0d want 0/0", if_valid, imem_address);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * i)) begin
                errors++;
                $display("FAIL rst_stall_resume[%0d] valid=%b pc=%h want 1/%h", i, if_valid, if_pc, 32'(4 * i));
            end
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        reset = 1'b1;
        step();
        checks++;
        if (perf_fetch !== 32'h0 || perf_stall !== 32'h0) begin
            errors++;
            $display("FAIL perf_reset fetch=%0d stall=%0d want 0/0", perf_fetch, perf_stall);
        end
        reset = 1'b0; id_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        id_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (perf_fetch !== 32'd10 || perf_stall !== 32'd3) begin
            errors++;
            $display("FAIL perf_counts fetch=%0d stall=%0d want 10/3", perf_fetch, perf_stall);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (perf_fetch !== 32'h0 || perf_stall !== 32'h0) begin
            errors++;
            $display("FAIL perf_clear fetch=%0d stall=%0d want 0/0", perf_fetch, perf_stall);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; id_ready = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        #1;
        test_reset();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_mid_stall();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
